// File: rtl/trans_cbcr_seq_if.sv
// Pixel-in / pixel-out valid-ready bundle for the luma-dependent chroma transform.
interface trans_cbcr_seq_if #(
    parameter int DW = 8
);
    logic [DW-1:0] y;
    logic [DW-1:0] cb;
    logic [DW-1:0] cr;
    logic          bypass;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] cb_t;
    logic [DW-1:0] cr_t;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output y, cb, cr, bypass, in_valid, out_ready,
        input  in_ready, cb_t, cr_t, out_valid
    );

    modport slave (
        input  y, cb, cr, bypass, in_valid, out_ready,
        output in_ready, cb_t, cr_t, out_valid
    );
endinterface

// File: rtl/trans_cbcr_seq.sv
// Luma-dependent Cb/Cr rescaling to the reference skin cluster at K_H,
// using one shared restoring divider, one pixel in flight.
module trans_cbcr_seq #(
    parameter int DW      = 8,
    parameter int Y_MIN   = 16,
    parameter int Y_MAX   = 235,
    parameter int K_L     = 125,
    parameter int K_H     = 188,
    parameter int W_CB    = 46,
    parameter int WL_CB   = 23,
    parameter int WH_CB   = 14,
    parameter int W_CR    = 38,
    parameter int WL_CR   = 20,
    parameter int WH_CR   = 10,
    parameter int CB_K    = 108,
    parameter int CB_LO_D = 10,
    parameter int CB_HI_D = 10,
    parameter int CR_K    = 154,
    parameter int CR_LO_D = 10,
    parameter int CR_HI_D = 22
) (
    input logic           clk,
    input logic           rst,
    trans_cbcr_seq_if.slave bus
);
    localparam int NW   = 2 * DW;
    localparam int CW   = $clog2(NW + 1);
    localparam int MAXV = (1 << DW) - 1;
    localparam logic [CW-1:0] LAST = CW'(NW);

    typedef enum logic [1:0] {IDLE, DIV, ADJ, OUT} state_t;
    state_t state_q, state_d;

    logic [DW-1:0] y_r, cb_r, cr_r, cb_t_r, cr_t_r;
    logic          lo_r;
    logic [2:0]    idx_r;
    logic [CW-1:0] cnt_r;
    logic [DW:0]   rem_r, dsr_r;
    logic [NW-1:0] quo_r;
    logic [DW:0]   wcb_r, wcr_r, cbm_r, crm_r;
    logic [NW-1:0] qb_r, qr_r;

    logic [DW-1:0] yc_in;
    logic          pass_in;

    always_comb begin
        yc_in = bus.y;
        if (bus.y < DW'(Y_MIN))
            yc_in = DW'(Y_MIN);
        else if (bus.y > DW'(Y_MAX))
            yc_in = DW'(Y_MAX);
    end

    assign pass_in = bus.bypass ||
        (yc_in >= DW'(K_L) && yc_in <= DW'(K_H));

    // distances to the nearest cluster end and to the knee
    logic [DW-1:0] a, b, dd;
    assign a  = lo_r ? y_r - DW'(Y_MIN) : DW'(Y_MAX) - y_r;
    assign b  = lo_r ? DW'(K_L) - y_r : y_r - DW'(K_H);
    assign dd = lo_r ? DW'(K_L - Y_MIN) : DW'(Y_MAX - K_H);

    logic [DW:0] dcb, dcr;
    logic        neg_b, neg_r;
    assign neg_b = {1'b0, cb_r} < cbm_r;
    assign neg_r = {1'b0, cr_r} < crm_r;
    assign dcb = neg_b ? cbm_r - {1'b0, cb_r} : {1'b0, cb_r} - cbm_r;
    assign dcr = neg_r ? crm_r - {1'b0, cr_r} : {1'b0, cr_r} - crm_r;

    logic [NW-1:0] num;
    logic [DW:0]   den;

    always_comb begin
        num = '0;
        den = {1'b0, dd};
        case (idx_r)
            3'd0: num = NW'(32'(a) * 32'(lo_r ? W_CB - WL_CB : W_CB - WH_CB));
            3'd1: num = NW'(32'(a) * 32'(lo_r ? W_CR - WL_CR : W_CR - WH_CR));
            3'd2: num = NW'(32'(b) * 32'(lo_r ? CB_LO_D : CB_HI_D));
            3'd3: num = NW'(32'(b) * 32'(lo_r ? CR_LO_D : CR_HI_D));
            3'd4: begin
                num = NW'(32'(dcb) * 32'(W_CB));
                den = wcb_r;
            end
            3'd5: begin
                num = NW'(32'(dcr) * 32'(W_CR));
                den = wcr_r;
            end
            default: ;
        endcase
    end

    logic [DW+1:0] rem_sh;
    logic          ge;
    logic [DW:0]   rem_n;
    logic [NW-1:0] quo_n;
    assign rem_sh = {rem_r, quo_r[NW-1]};
    assign ge     = rem_sh >= {1'b0, dsr_r};
    assign rem_n  = ge ? (DW+1)'(rem_sh - {1'b0, dsr_r}) : rem_sh[DW:0];
    assign quo_n  = {quo_r[NW-2:0], ge};

    function automatic logic [DW-1:0] adj(
        input int k, input logic neg, input logic [NW-1:0] q
    );
        int v;
        v = neg ? k - int'(q) : k + int'(q);
        if (v < 0)
            adj = '0;
        else if (v > MAXV)
            adj = '1;
        else
            adj = DW'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = pass_in ? OUT : DIV;
            DIV:  if (cnt_r == LAST && idx_r == 3'd5) state_d = ADJ;
            ADJ:  state_d = OUT;
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y_r <= '0; cb_r <= '0; cr_r <= '0; lo_r <= 1'b0;
            idx_r <= '0; cnt_r <= '0;
            rem_r <= '0; quo_r <= '0; dsr_r <= '0;
            wcb_r <= '0; wcr_r <= '0; cbm_r <= '0; crm_r <= '0;
            qb_r <= '0; qr_r <= '0;
            cb_t_r <= '0; cr_t_r <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    y_r   <= yc_in;
                    cb_r  <= bus.cb;
                    cr_r  <= bus.cr;
                    lo_r  <= yc_in < DW'(K_L);
                    idx_r <= '0;
                    cnt_r <= '0;
                    if (pass_in) begin
                        cb_t_r <= bus.cb;
                        cr_t_r <= bus.cr;
                    end
                end
                DIV: if (cnt_r == '0) begin
                    rem_r <= '0;
                    quo_r <= num;
                    dsr_r <= den;
                    cnt_r <= CW'(1);
                end else begin
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    if (cnt_r == LAST) begin
                        cnt_r <= '0;
                        idx_r <= idx_r + 3'd1;
                        case (idx_r)
                            3'd0: wcb_r <= (DW+1)'(32'(quo_n) +
                                32'(lo_r ? WL_CB : WH_CB));
                            3'd1: wcr_r <= (DW+1)'(32'(quo_n) +
                                32'(lo_r ? WL_CR : WH_CR));
                            3'd2: cbm_r <= (DW+1)'(32'(CB_K) + 32'(quo_n));
                            3'd3: crm_r <= (DW+1)'(lo_r ?
                                32'(CR_K) - 32'(quo_n) :
                                32'(CR_K) + 32'(quo_n));
                            3'd4: qb_r <= quo_n;
                            3'd5: qr_r <= quo_n;
                            default: ;
                        endcase
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ADJ: begin
                    cb_t_r <= adj(CB_K, neg_b, qb_r);
                    cr_t_r <= adj(CR_K, neg_r, qr_r);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == OUT;
    assign bus.cb_t      = cb_t_r;
    assign bus.cr_t      = cr_t_r;
endmodule

// File: tb/tb_trans_cbcr_seq.sv
// Directed and random checks of trans_cbcr_seq against an arithmetic
// model of the cluster rescaling.
module tb_trans_cbcr_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    trans_cbcr_seq_if #(.DW(8)) bus ();

    trans_cbcr_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input integer obs, input integer exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // cluster width/mean from luma, then rescale the chroma offset
    function automatic void model(
        input int y, input int cb, input int cr, input bit byp,
        output int ecb, output int ecr, output int lat
    );
        int yc, a, b, d, wcb, wcr, cbm, crm, qb, qr;
        bit lo;
        yc = (y < 16) ? 16 : (y > 235) ? 235 : y;
        if (byp || (yc >= 125 && yc <= 188)) begin
            ecb = cb; ecr = cr; lat = 1;
            return;
        end
        lo = yc < 125;
        a = lo ? yc - 16 : 235 - yc;
        b = lo ? 125 - yc : yc - 188;
        d = lo ? 125 - 16 : 235 - 188;
        wcb = lo ? 23 + a * (46 - 23) / d : 14 + a * (46 - 14) / d;
        wcr = lo ? 20 + a * (38 - 20) / d : 10 + a * (38 - 10) / d;
        cbm = 108 + b * 10 / d;
        crm = lo ? 154 - b * 10 / d : 154 + b * 22 / d;
        qb = ((cb >= cbm) ? cb - cbm : cbm - cb) * 46 / wcb;
        qr = ((cr >= crm) ? cr - crm : crm - cr) * 38 / wcr;
        ecb = clamp8((cb >= cbm) ? 108 + qb : 108 - qb);
        ecr = clamp8((cr >= crm) ? 154 + qr : 154 - qr);
        lat = 104;
    endfunction

    task automatic drive(input int y, input int cb, input int cr, input bit byp);
        bus.y = 8'(y);
        bus.cb = 8'(cb);
        bus.cr = 8'(cr);
        bus.bypass = byp;
        bus.in_valid = 1'b1;
    endtask

    // returns edges from accept to first out_valid, 300 on timeout
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_pixel(
        input string tag, input int y, input int cb, input int cr, input bit byp
    );
        int ecb, ecr, elat, lat;
        model(y, cb, cr, byp, ecb, ecr, elat);
        drive(y, cb, cr, byp);
        check({tag, "_rdy"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_cb"}, bus.cb_t, ecb);
        check({tag, "_cr"}, bus.cr_t, ecr);
        @(posedge clk); #1;
        check({tag, "_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        int lat, stale, ecb, ecr, elat;
        rst = 1'b0;
        bus.y = '0; bus.cb = '0; bus.cr = '0;
        bus.bypass = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cb_t", bus.cb_t, 0);
        check("rst_cr_t", bus.cr_t, 0);
        rst = 1'b1;

        run_pixel("pass_mid", 150, 100, 160, 1'b0);
        run_pixel("pass_byp", 16, 77, 201, 1'b1);
        run_pixel("lo_a", 16, 128, 154, 1'b0);
        run_pixel("lo_b", 16, 118, 144, 1'b0);
        run_pixel("hi_a", 235, 125, 170, 1'b0);
        run_pixel("hi_yclamp", 250, 125, 170, 1'b0);
        run_pixel("clamp_top", 16, 255, 154, 1'b0);
        run_pixel("clamp_bot", 16, 0, 144, 1'b0);
        run_pixel("knee_lo", 124, 90, 200, 1'b0);
        run_pixel("knee_hi", 189, 140, 120, 1'b0);

        // backpressure: hold the first result, second pixel must wait
        bus.out_ready = 1'b0;
        model(16, 128, 154, 1'b0, ecb, ecr, elat);
        drive(16, 128, 154, 1'b0);
        @(posedge clk); #1;
        drive(150, 100, 160, 1'b0);
        wait_out(lat);
        check("bp_lat", lat, elat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_cb", bus.cb_t, ecb);
            check("bp_cr", bus.cr_t, ecr);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_cb", bus.cb_t, 100);
        check("bp_next_cr", bus.cr_t, 160);
        @(posedge clk); #1;

        // reset in the middle of the divide sequence
        drive(16, 128, 154, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_cb_t", bus.cb_t, 0);
        check("mid_rst_cr_t", bus.cr_t, 0);
        stale = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        check("mid_rst_stale", stale, 0);

        for (int i = 0; i < 16; i++) begin
            run_pixel("rand", int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
